// File: rtl/seg_display_pkg.sv
// Shared constants for the seven-segment scan display: segment patterns,
// scan index assignments and adjust-mode encoding.
package seg_display_pkg;

   typedef logic [3:0] bcd_t;
   typedef logic [6:0] seg_t;

   // Active-low {g,f,e,d,c,b,a}
   localparam seg_t SEG_0     = 7'h40;
   localparam seg_t SEG_1     = 7'h79;
   localparam seg_t SEG_2     = 7'h24;
   localparam seg_t SEG_3     = 7'h30;
   localparam seg_t SEG_4     = 7'h19;
   localparam seg_t SEG_5     = 7'h12;
   localparam seg_t SEG_6     = 7'h02;
   localparam seg_t SEG_7     = 7'h78;
   localparam seg_t SEG_8     = 7'h00;
   localparam seg_t SEG_9     = 7'h10;
   localparam seg_t SEG_DASH  = 7'h3F;
   localparam seg_t SEG_BLANK = 7'h7F;

   localparam logic [1:0] SEC0 = 2'd0;
   localparam logic [1:0] SEC1 = 2'd1;
   localparam logic [1:0] MIN0 = 2'd2;
   localparam logic [1:0] MIN1 = 2'd3;

   localparam logic [1:0] ADJ_RUN = 2'd0;
   localparam logic [3:0] AN_OFF  = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder; non-BCD codes
// render as a dash so a corrupted digit is visible rather than misleading.
module bcd_to_seg7
   import seg_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit common-anode scan driver: frame-coherent digit snapshot,
// BCD decode, decimal point between minutes and seconds, adjust blinking.
module seg_scan_display
   import seg_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] min1,
   input  logic [3:0] min0,
   input  logic [3:0] sec1,
   input  logic [3:0] sec0,
   input  logic [1:0] adjust,
   input  logic       select,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

   logic [RW-1:0] div_cnt;
   logic [1:0]    idx;
   bcd_t          snap [4];
   logic [BW-1:0] blink_cnt;
   logic          phase;

   logic          frame_start;
   logic          adj_mode;
   logic          in_sel_pair;
   logic          blank;
   logic [6:0]    seg_dec;

   assign frame_start = (div_cnt == '0) && (idx == SEC0);
   assign adj_mode    = (adjust != ADJ_RUN);
   assign in_sel_pair = select ? (idx == SEC0 || idx == SEC1)
                               : (idx == MIN0 || idx == MIN1);
   // adjust/select are deliberately live so the blink target tracks select at once
   assign blank       = adj_mode && !phase && in_sel_pair;

   bcd_to_seg7 u_dec (
      .bcd (snap[idx]),
      .seg (seg_dec)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         idx     <= SEC0;
      end else if (div_cnt == REFRESH_LAST) begin
         div_cnt <= '0;
         idx     <= idx + 2'd1;
      end else begin
         div_cnt <= div_cnt + RW'(1);
      end
   end

   // All four digits captured together so a carry mid-frame never tears the display
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) snap[i] <= '0;
      end else if (frame_start) begin
         snap[SEC0] <= sec0;
         snap[SEC1] <= sec1;
         snap[MIN0] <= min0;
         snap[MIN1] <= min1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !adj_mode) begin
         blink_cnt <= '0;
         phase     <= 1'b1;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= '0;
         phase     <= ~phase;
      end else begin
         blink_cnt <= blink_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || blank) begin
         an  <= AN_OFF;
         seg <= SEG_BLANK;
         dp  <= 1'b1;
      end else begin
         an  <= ~(4'b0001 << idx);
         seg <= seg_dec;
         dp  <= (idx != MIN0);
      end
   end

endmodule

// File: doc/seg_scan_display.md
# seg_scan_display

Display-side consumer of the stopwatch's four BCD time digits (min1, min0, sec1, sec0) and its adjust/select controls. The block time-multiplexes the digits onto a 4-digit common-anode seven-segment display. It latches a coherent snapshot of the digits once per scan frame, decodes BCD to segments, and blinks the digit pair under adjustment. It sits between the counter and the board's segment/anode pins.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays enabled (≥2).
- `BLINK_DIV`, default 25000000: clock cycles per blink half-period (≥2).
- `clk`  in  1: single system clock; all state on rising edge.
- `reset`  in  1: synchronous, active-high.
- `min1`, `min0`, `sec1`, `sec0`  in  4 each: BCD digits from the counter.
- `adjust`  in  2: 0 = run; any nonzero value = adjust mode.
- `select`  in  1: in adjust mode, 1 = seconds pair blinks, 0 = minutes pair blinks.
- `seg`  out  7: {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.
- `an`  out  4: digit enables, active-low; `an[i]` is digit index i.

## Operation
- **Scan order (index → source):**
  - 0 → `sec0`
  - 1 → `sec1`
  - 2 → `min0`
  - 3 → `min1`
- **Refresh divider:** counts 0..REFRESH_DIV-1. At the terminal count it wraps to 0 and the index advances, 3 → 0.
- **Snapshot:**
  - All four digits load together on any cycle where divider == 0 and index == 0, i.e. frame start.
  - Mid-frame input changes are not displayed until the next frame, so there is no tearing.
- **Decode:**
  - 0..9 use standard patterns: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Codes 10..15 display a dash, 0x3F.
- **Decimal point:** `dp`=0 only at index 2 (separates minutes from seconds); otherwise 1.
- **Blink:**
  - Counter runs 0..BLINK_DIV-1 and toggles `phase` at the terminal count.
  - `phase`=1 means visible.
  - While `adjust`==0, the counter is held at 0 and `phase` is forced to 1.
  - Entering adjust mode therefore always starts with a full visible half-period.
- **Blanking:**
  - Applies when `adjust`!=0, `phase`=0, and the current index belongs to the selected pair (indices 0–1 if `select`=1, indices 2–3 if `select`=0).
  - A blanked digit drives `an`=4'b1111, `seg`=7'h7F, `dp`=1.
  - The unselected pair always shows normally.
- **Live inputs:** `adjust` and `select` are used live, not snapshotted, so the blink target follows `select` immediately.

## Timing
- **Registered outputs:** `seg`, `dp` and `an` are registered. Their values after edge N+1 reflect the index, snapshot and blink state held after edge N, so latency is 1 cycle.
- **Reset values:**
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1
  - index=0, divider=0, snapshot=all zeros
  - blink counter=0, `phase`=1
- **First edge with `reset` low:**
  - The snapshot loads.
  - Outputs show index 0 from the zero snapshot: `an`=4'b1110, `seg`=0x40.
  - From the next edge, outputs show the loaded digits.
- **Digit dwell:** each digit is enabled for exactly REFRESH_DIV cycles. A frame is 4×REFRESH_DIV cycles.
- **No ghosting:** exactly one `an` bit is low in any non-blanked cycle.
- **Reset mid-frame:** takes effect on the next edge. Outputs return to reset values the cycle after; the scan restarts at index 0.
- **Simultaneous events:** a blink toggle coinciding with an index advance is applied independently. The output on the following edge uses the new `phase` and the new index.

## Structure
- **Package `seg_display_pkg`:**
  - Segment pattern constants for 0–9, dash and blank.
  - Digit-index constants SEC0=0, SEC1=1, MIN0=2, MIN1=3.
  - Adjust-mode constant ADJ_RUN=2'd0.
- **Sub-module `bcd_to_seg7`:** combinational 4-bit BCD → 7-bit active-low decoder, with dash for codes above 9.
- **Top level:** refresh divider, index counter, snapshot register, blink counter and output registers.
- **Counter widths:** `$clog2` of the respective DIV parameter.

## Test plan
Bench parameters: REFRESH_DIV=4, BLINK_DIV=16.
- **Reset and scan order:** reset 3 cycles, then inputs 1,2,3,4 (min1..sec0).
  - Required: `an` sequence 1110, 1101, 1011, 0111, each held 4 cycles.
  - Required `seg`: 0x19 (4), 0x30 (3), 0x24 (2), 0x79 (1).
  - Required: `dp`=0 only while `an`=1011.
- **Snapshot coherence:** change `sec0` from 4 to 5 mid-frame.
  - Required: 0x19 persists until the next frame start; the new frame shows 0x12.
- **Invalid BCD:** `min1`=4'hC.
  - Required: `seg`=0x3F when `an`=0111.
- **Blink seconds:** `adjust`=1, `select`=1.
  - Required: indices 0–1 visible for 16 cycles, then `an`=1111 and `seg`=0x7F in their slots for 16 cycles.
  - Required: minutes are never blanked.
  - Setting `adjust`=0 restores full display on the next edge.
- **Select switch:** switch `select` from 1 to 0 during the off phase.
  - Required: the minutes slots blank immediately and the seconds slots reappear.
- **Mid-operation reset:** assert `reset` at index 2 during adjust mode.
  - Required: all-off outputs the next cycle; the scan resumes at index 0 with `phase`=1 after release.
